midi_rx_sequencer: RTL and testbench

Drains received bytes from the `simpleuart` receive side and assembles complete MIDI channel-voice messages for the synth voice logic. It owns the UART read strobe, tracks running status, filters by channel, and drops system-common/SysEx traffic. It emits system-realtime bytes on a separate strobe. It sits between `simpleuart` and the note/voice allocator in the MIDI example top level.

---
 rtl/midi_pkg.sv | 43 ++++
 rtl/midi_byte_classify.sv | 25 ++
 rtl/midi_rx_sequencer.sv | 156 +++++++++++++++
 tb/tb_midi_rx_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared types, constants and helpers for the MIDI receive path.
//   - midi_state_e : message assembly states
//   - status nibble constants for channel-voice messages
//   - midi_msg_t   : assembled channel-voice message payload
//   - midi_data_len: number of data bytes carried by a channel status byte
package midi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2,
        SKIP = 2'd3
    } midi_state_e;

    localparam logic [NIB_W-1:0] NOTE_OFF = 4'h8;
    localparam logic [NIB_W-1:0] NOTE_ON  = 4'h9;
    localparam logic [NIB_W-1:0] POLY_AT  = 4'hA;
    localparam logic [NIB_W-1:0] CC       = 4'hB;
    localparam logic [NIB_W-1:0] PROG     = 4'hC;
    localparam logic [NIB_W-1:0] CH_AT    = 4'hD;
    localparam logic [NIB_W-1:0] BEND     = 4'hE;

    typedef struct packed {
        logic [BYTE_W-1:0] status;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
    } midi_msg_t;

    // Program change and channel aftertouch carry one data byte, all others two.
    function automatic logic [1:0] midi_data_len(input logic [BYTE_W-1:0] status);
        logic [1:0] len;
        case (status[7:4])
            PROG, CH_AT: len = 2'd1;
            default:     len = 2'd2;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// midi_byte_classify: combinational classification of one received MIDI byte.
// Ports:
//   byte_in        - received byte
//   is_data        - bit7 clear
//   is_chan_status - 0x80-0xEF
//   is_sys_common  - 0xF0-0xF7 (system common / SysEx)
//   is_realtime    - 0xF8-0xFF
module midi_byte_classify
    import midi_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    output logic              is_data,
    output logic              is_chan_status,
    output logic              is_sys_common,
    output logic              is_realtime
);

    always_comb begin
        is_data        = !byte_in[7];
        is_chan_status = byte_in[7] && (byte_in[6:4] != 3'b111);
        is_sys_common  = (byte_in[7:3] == 5'b11110);
        is_realtime    = (byte_in[7:3] == 5'b11111);
    end

endmodule

// File: rtl/midi_rx_sequencer.sv
// midi_rx_sequencer: drains bytes from the UART receive buffer and assembles
// complete MIDI channel-voice messages, with running status, channel filtering,
// dropping of system-common/SysEx traffic and a separate realtime strobe.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   recv_buf_valid  - UART holds an unread byte
//   reg_dat_do      - UART receive byte
//   reg_dat_re      - read strobe to the UART (combinational)
//   msg_valid/ready - message handshake to the voice allocator
//   msg_status      - status byte (0x80-0xEF)
//   msg_data1/2     - data bytes (data2 = 0 for one-byte messages)
//   rt_valid        - one-cycle pulse per realtime byte
//   rt_byte         - realtime byte (0xF8-0xFF)
module midi_rx_sequencer
    import midi_pkg::*;
#(
    parameter int unsigned CHANNEL     = 16,
    parameter bit          VEL0_IS_OFF = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recv_buf_valid,
    input  logic [BYTE_W-1:0] reg_dat_do,
    output logic              reg_dat_re,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic [BYTE_W-1:0] msg_status,
    output logic [DATA_W-1:0] msg_data1,
    output logic [DATA_W-1:0] msg_data2,
    output logic              rt_valid,
    output logic [BYTE_W-1:0] rt_byte
);

    localparam bit               OMNI   = (CHANNEL >= 16);
    localparam logic [NIB_W-1:0] CH_NIB = NIB_W'(CHANNEL);

    midi_state_e       state_q, state_d;
    logic [BYTE_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    midi_msg_t         msg_q, msg_d;
    logic              msg_valid_q, msg_valid_d;
    logic              rt_valid_q, rt_valid_d;
    logic [BYTE_W-1:0] rt_byte_q, rt_byte_d;

    logic              is_data;
    logic              is_chan_status;
    logic              is_sys_common;
    logic              is_realtime;

    logic              complete;
    logic [DATA_W-1:0] d2_cur;
    logic              chan_match;
    logic              vel0_off;

    // Byte class decode of the UART head byte.
    midi_byte_classify u_classify (
        .byte_in        (reg_dat_do),
        .is_data        (is_data),
        .is_chan_status (is_chan_status),
        .is_sys_common  (is_sys_common),
        .is_realtime    (is_realtime)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rs_q        <= '0;
            d1_q        <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            rt_valid_q  <= 1'b0;
            rt_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            d1_q        <= d1_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            rt_valid_q  <= rt_valid_d;
            rt_byte_q   <= rt_byte_d;
        end
    end

    // Next-state, byte consumption and message completion.
    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        d1_d        = d1_q;
        msg_d       = msg_q;
        msg_valid_d = msg_valid_q && !msg_ready;
        rt_valid_d  = 1'b0;
        rt_byte_d   = rt_byte_q;
        complete    = 1'b0;
        d2_cur      = '0;
        chan_match  = OMNI || (rs_q[3:0] == CH_NIB);
        vel0_off    = 1'b0;

        // Nothing is read while a message is held, realtime bytes included.
        reg_dat_re  = recv_buf_valid && !msg_valid_q;

        if (reg_dat_re) begin
            if (is_realtime) begin
                // Realtime bytes pass through without disturbing assembly.
                rt_valid_d = 1'b1;
                rt_byte_d  = reg_dat_do;
            end else if (is_chan_status) begin
                // A status byte always restarts the message.
                rs_d    = reg_dat_do;
                state_d = D1;
            end else if (is_sys_common) begin
                // System common cancels running status; skip its payload.
                rs_d    = '0;
                state_d = SKIP;
            end else if (is_data) begin
                case (state_q)
                    IDLE, D1: begin
                        // In IDLE a data byte only counts under running status.
                        if (rs_q != '0) begin
                            d1_d = reg_dat_do[DATA_W-1:0];
                            if (midi_data_len(rs_q) == 2'd1) begin
                                complete = 1'b1;
                            end else begin
                                state_d = D2;
                            end
                        end
                    end
                    D2: begin
                        d2_cur   = reg_dat_do[DATA_W-1:0];
                        complete = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (complete) begin
            state_d  = IDLE;
            vel0_off = VEL0_IS_OFF && (rs_q[7:4] == NOTE_ON) && (d2_cur == '0);
            if (chan_match) begin
                msg_valid_d  = 1'b1;
                msg_d.status = vel0_off ? {NOTE_OFF, rs_q[3:0]} : rs_q;
                msg_d.data1  = d1_d;
                msg_d.data2  = d2_cur;
            end
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_status = msg_q.status;
    assign msg_data1  = msg_q.data1;
    assign msg_data2  = msg_q.data2;
    assign rt_valid   = rt_valid_q;
    assign rt_byte    = rt_byte_q;

endmodule

// File: tb/tb_midi_rx_sequencer.sv
// tb_midi_rx_sequencer: three sequencer instances (omni/vel0-off, omni/vel0-kept,
// channel 2) receive the same byte stream through independent UART source
// models. A stream-level reference model predicts messages and realtime bytes
// at the moment each byte is consumed; per-instance monitors check them.
module tb_midi_rx_sequencer;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    bit         rand_ready;
    bit         force_ready;
    bit         gaps;
    int         n_tests;
    int         n_fail;

    logic [7:0]  src_q [NI][$];
    logic [21:0] exp_q [NI][$];
    logic [7:0]  rs_m  [NI];
    logic [6:0]  d1_m  [NI];
    int          cnt_m [NI];
    logic [NI-1:0] mv;

    always #5 clk = ~clk;

    function automatic int unsigned chan_of(input int g);
        return (g == 2) ? 2 : 16;
    endfunction

    function automatic bit vel0_of(input int g);
        return (g != 1);
    endfunction

    function automatic void chk(input bit ok, input string nm, input int g,
                                input int unsigned act, input int unsigned exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, g, act, exp, $time);
        end
    endfunction

    // Stream-level reference: running status, byte counting, filtering.
    function automatic void model_step(input int g, input logic [7:0] b,
                                       output bit emsg, output bit ert);
        int         need;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [7:0] st;
        emsg = 1'b0;
        ert  = 1'b0;
        if (b >= 8'hF8) begin
            ert = 1'b1;
        end else if (b >= 8'hF0) begin
            rs_m[g]  = 8'h00;
            cnt_m[g] = 0;
        end else if (b >= 8'h80) begin
            rs_m[g]  = b;
            cnt_m[g] = 0;
        end else if (rs_m[g] != 8'h00) begin
            need = (rs_m[g] >= 8'hC0 && rs_m[g] < 8'hE0) ? 1 : 2;
            if (cnt_m[g] == 0) begin
                d1_m[g]  = b[6:0];
                cnt_m[g] = 1;
            end else begin
                cnt_m[g] = 2;
            end
            if (cnt_m[g] == need) begin
                d1 = d1_m[g];
                d2 = (need == 2) ? b[6:0] : 7'd0;
                cnt_m[g] = 0;
                if (chan_of(g) == 16 || int'(rs_m[g] % 16) == int'(chan_of(g))) begin
                    st = (vel0_of(g) && rs_m[g] / 16 == 8'd9 && d2 == 7'd0) ? rs_m[g] - 8'h10 : rs_m[g];
                    exp_q[g].push_back({st, d1, d2});
                    emsg = 1'b1;
                end
            end
        end
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned CH = (g == 2) ? 2 : 16;
        localparam bit          V0 = (g == 1) ? 1'b0 : 1'b1;

        logic       rv;
        logic [7:0] rd;
        logic       re;
        logic       rdy;
        logic       mvl;
        logic [7:0] ms;
        logic [6:0] m1;
        logic [6:0] m2;
        logic       rtv;
        logic [7:0] rtb;

        midi_rx_sequencer #(.CHANNEL(CH), .VEL0_IS_OFF(V0)) dut (
            .clk            (clk),
            .reset          (reset),
            .recv_buf_valid (rv),
            .reg_dat_do     (rd),
            .reg_dat_re     (re),
            .msg_valid      (mvl),
            .msg_ready      (rdy),
            .msg_status     (ms),
            .msg_data1      (m1),
            .msg_data2      (m2),
            .rt_valid       (rtv),
            .rt_byte        (rtb)
        );

        assign mv[g] = mvl;

        // UART source, consumer and monitor for this instance.
        initial begin : agent
            bit          held;
            bit          exp_msg;
            bit          exp_rt;
            logic [21:0] saved;
            logic [21:0] act;
            logic [21:0] e;
            logic [7:0]  exp_rt_b;
            logic [7:0]  b;
            held = 0; exp_msg = 0; exp_rt = 0; exp_rt_b = 8'h00; saved = '0;
            rv = 1'b0; rd = 8'h00; rdy = 1'b0;
            forever begin
                @(negedge clk);
                act = {ms, m1, m2};
                if (reset) begin
                    chk(!mvl && !rtv && act == 22'd0 && rtb == 8'h00, "reset_values", g,
                        32'({mvl, rtv, rtb, act}), 0);
                    held = 0; exp_msg = 0; exp_rt = 0;
                    rv = 1'b0; rdy = 1'b0;
                end else begin
                    if (exp_msg) begin
                        chk(mvl, "msg_latency", g, 32'(mvl), 1);
                        e = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : 22'h3FFFFF;
                        if (mvl) chk(act == e, "msg_content", g, 32'(act), 32'(e));
                        held  = mvl;
                        saved = act;
                    end else if (!held) begin
                        chk(!mvl, "msg_unexpected", g, 32'(act), 0);
                        if (mvl) begin
                            held  = 1;
                            saved = act;
                        end
                    end else begin
                        chk(mvl && act == saved, "msg_stable", g, 32'({mvl, act}), 32'({1'b1, saved}));
                    end
                    chk(rtv == exp_rt, "rt_timing", g, 32'(rtv), 32'(exp_rt));
                    if (exp_rt && rtv) chk(rtb == exp_rt_b, "rt_byte", g, 32'(rtb), 32'(exp_rt_b));
                    exp_msg = 0;
                    exp_rt  = 0;

                    rdy = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
                    if (src_q[g].size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                        rv = 1'b1;
                        rd = src_q[g][0];
                    end else begin
                        rv = 1'b0;
                        rd = 8'($urandom);
                    end
                    #4;
                    chk(re == (rv && !mvl), "read_strobe", g, 32'(re), 32'(rv && !mvl));
                    if (re) begin
                        b = src_q[g].pop_front();
                        model_step(g, b, exp_msg, exp_rt);
                        exp_rt_b = b;
                    end
                    if (mvl && rdy) held = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        for (int g = 0; g < NI; g++) src_q[g].push_back(b);
    endtask

    task automatic wait_idle(input string nm);
        int cyc;
        bit idle;
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            idle = (mv == '0);
            for (int g = 0; g < NI; g++)
                if (src_q[g].size() > 0 || exp_q[g].size() > 0) idle = 0;
            cyc++;
        end while (!idle && cyc < 20000);
        chk(idle, {"drain_", nm}, 0, 32'(cyc), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rs_m[g]  = 8'h00;
            cnt_m[g] = 0;
            exp_q[g].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int         r;
        logic [7:0] b;
        n_tests = 0; n_fail = 0;
        rand_ready = 0; force_ready = 1; gaps = 0;
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rs_m[g] = 8'h00; d1_m[g] = 7'd0; cnt_m[g] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        send(8'h90); send(8'h3C); send(8'h64);
        wait_idle("note_on");
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
        wait_idle("running_status");
        send(8'h90); send(8'h3C); send(8'h00);
        wait_idle("vel0");
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); send(8'hC5); send(8'h07);
        wait_idle("interleave");
        send(8'h91); send(8'h3C); send(8'h64);
        send(8'h92); send(8'h3C); send(8'h64);
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h40);
        wait_idle("filter");

        force_ready = 0;
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50); send(8'hFA);
        repeat (20) @(negedge clk);
        force_ready = 1;
        wait_idle("backpressure");

        send(8'h90); send(8'h3C);
        wait_idle("pre_reset");
        do_reset();
        send(8'h64);
        wait_idle("post_reset");

        rand_ready = 1; gaps = 1;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = 8'h00;
            else if (r < 55) b = 8'($urandom_range(0, 127));
            else if (r < 80) b = {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 3))};
            else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            send(b);
        end
        repeat (300) @(negedge clk);
        do_reset();
        wait_idle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
